// File: rtl/digitube_pkg.sv
// Shared constants for the digit-tube scanning driver: segment codes,
// anode codes and the dark output word.
package digitube_pkg;

    // Active-low segment patterns, bit order {CG,CF,CE,CD,CC,CB,CA}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // One-hot, active-high anode selects
    localparam logic [3:0] AN_DIG0 = 4'b0001;
    localparam logic [3:0] AN_DIG1 = 4'b0010;
    localparam logic [3:0] AN_DIG2 = 4'b0100;
    localparam logic [3:0] AN_DIG3 = 4'b1000;

    // No anode driven, DP and all segments off
    localparam logic [11:0] DIGI_OFF = 12'h0FF;

    function automatic logic [3:0] an_code(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = AN_DIG0;
            2'd1:    an = AN_DIG1;
            2'd2:    an = AN_DIG2;
            default: an = AN_DIG3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/digitube_driver_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
    import digitube_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digitube_driver.sv
// Four-digit multiplexed tube driver. A staged copy of the display value
// is committed to the shadow copy only at frame boundaries, so a frame is
// always drawn from one consistent value.
module digitube_driver
    import digitube_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        enable,
    output logic [11:0] digi_out,
    output logic        frame_done
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow_val;
    logic [3:0]       shadow_dp;
    logic [15:0]      staged_val;
    logic [3:0]       staged_dp;
    logic             pending;

    logic             tick;
    logic             boundary;
    logic [3:0]       cur_nibble;
    logic [6:0]       seg_raw;
    logic             blank_digit;
    logic [6:0]       seg_sel;

    assign tick     = enable && (cnt == CNT_LAST);
    assign boundary = tick && (idx == 2'd3);

    // Digit hold-time divider and digit index; both freeze while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (enable) begin
            if (tick) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Staged/shadow double buffer: a load at a boundary or while dark
    // bypasses staging, since there is no frame in flight to protect
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_val <= 16'h0000;
            shadow_dp  <= 4'b0000;
            staged_val <= 16'h0000;
            staged_dp  <= 4'b0000;
            pending    <= 1'b0;
        end else if (load && (boundary || !enable)) begin
            shadow_val <= data_in;
            shadow_dp  <= dp_in;
            pending    <= 1'b0;
        end else if (load) begin
            staged_val <= data_in;
            staged_dp  <= dp_in;
            pending    <= 1'b1;
        end else if (boundary && pending) begin
            shadow_val <= staged_val;
            shadow_dp  <= staged_dp;
            pending    <= 1'b0;
        end
    end

    // Select the nibble of the digit currently being scanned
    always_comb begin
        cur_nibble = shadow_val[3:0];
        case (idx)
            2'd0:    cur_nibble = shadow_val[3:0];
            2'd1:    cur_nibble = shadow_val[7:4];
            2'd2:    cur_nibble = shadow_val[11:8];
            default: cur_nibble = shadow_val[15:12];
        endcase
    end

    hex7seg u_hex7seg (
        .nibble (cur_nibble),
        .seg    (seg_raw)
    );

    // Leading-zero blanking: a digit goes dark when it and every higher
    // digit are zero; digit 0 always shows
    always_comb begin
        blank_digit = 1'b0;
        if (BLANK_LZ) begin
            case (idx)
                2'd1:    blank_digit = (shadow_val[15:4] == 12'h000);
                2'd2:    blank_digit = (shadow_val[15:8] == 8'h00);
                2'd3:    blank_digit = (shadow_val[15:12] == 4'h0);
                default: blank_digit = 1'b0;
            endcase
        end
        seg_sel = blank_digit ? SEG_BLANK : seg_raw;
    end

    // Registered scan word and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            digi_out   <= DIGI_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (enable) begin
                digi_out <= {an_code(idx), ~shadow_dp[idx], seg_sel};
            end else begin
                digi_out <= DIGI_OFF;
            end
        end
    end

endmodule

// File: tb/tb_digitube_driver.sv
// Randomised and directed bench for digitube_driver. Two instances (with
// and without leading-zero blanking) share stimulus and are compared every
// cycle against a behavioural model of the display rules.
module tb_digitube_driver;

    localparam int DIV = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        enable;
    logic [11:0] out_b;
    logic [11:0] out_n;
    logic        fd_b;
    logic        fd_n;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int          m_cnt, m_idx;
    logic [15:0] m_shadow, m_staged;
    logic [3:0]  m_sdp, m_stdp;
    bit          m_pend;
    logic [11:0] m_out_b, m_out_n;
    bit          m_fd;

    always #5 clk = ~clk;

    digitube_driver #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
        .load(load), .enable(enable), .digi_out(out_b), .frame_done(fd_b)
    );

    digitube_driver #(.SCAN_DIV(DIV), .BLANK_LZ(1'b0)) dut_n (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
        .load(load), .enable(enable), .digi_out(out_n), .frame_done(fd_n)
    );

    task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [11:0] exp_word(input int di, input logic [15:0] val,
                                             input logic [3:0] dpv, input bit blank);
        logic [15:0] upper;
        logic [6:0]  seg;
        logic [3:0]  an;
        upper = val >> (4 * di);
        seg   = SEG_TAB[upper[3:0]];
        if (blank && di > 0 && upper == 16'h0) seg = 7'h7F;
        an = 4'(1 << di);
        return {an, ~dpv[di], seg};
    endfunction

    function automatic bit at_boundary_next();
        return (m_cnt == DIV - 1) && (m_idx == 3);
    endfunction

    // Apply one cycle of inputs, advance the model, then compare outputs
    task automatic step(input bit rst_v, input bit ld_v, input bit en_v,
                        input logic [15:0] d_v, input logic [3:0] dp_v);
        bit tick, bnd;
        reset = rst_v; load = ld_v; enable = en_v; data_in = d_v; dp_in = dp_v;
        @(posedge clk);
        if (rst_v) begin
            m_cnt = 0; m_idx = 0; m_shadow = 16'h0; m_sdp = 4'h0;
            m_staged = 16'h0; m_stdp = 4'h0; m_pend = 0;
            m_out_b = 12'h0FF; m_out_n = 12'h0FF; m_fd = 0;
        end else begin
            tick = en_v && (m_cnt == DIV - 1);
            bnd  = tick && (m_idx == 3);
            m_out_b = en_v ? exp_word(m_idx, m_shadow, m_sdp, 1'b1) : 12'h0FF;
            m_out_n = en_v ? exp_word(m_idx, m_shadow, m_sdp, 1'b0) : 12'h0FF;
            m_fd = bnd;
            if (ld_v && (bnd || !en_v)) begin
                m_shadow = d_v; m_sdp = dp_v; m_pend = 0;
            end else if (ld_v) begin
                m_staged = d_v; m_stdp = dp_v; m_pend = 1;
            end else if (bnd && m_pend) begin
                m_shadow = m_staged; m_sdp = m_stdp; m_pend = 0;
            end
            if (en_v) begin
                if (tick) begin
                    m_cnt = 0; m_idx = (m_idx + 1) % 4;
                end else begin
                    m_cnt++;
                end
            end
        end
        #1;
        check_val("digi_out_blank", out_b, m_out_b);
        check_val("digi_out_noblank", out_n, m_out_n);
        check_val("frame_done", {11'd0, fd_b}, {11'd0, m_fd});
        check_val("frame_done_nb", {11'd0, fd_n}, {11'd0, m_fd});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
    endtask

    // Step idle cycles until the next cycle is a frame boundary
    task automatic seek_boundary(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 4 * DIV + 2; i++) begin
            if (at_boundary_next()) begin
                found = 1;
                break;
            end
            step(1'b0, 1'b0, 1'b1, 16'h0, 4'h0);
        end
        check_val(tag, {11'd0, found}, 12'd1);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; enable = 1'b1; data_in = '0; dp_in = '0;

        // Reset then an idle display of "0"
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'h0, 4'h0);
        check_val("reset_word", out_b, 12'h0FF);
        run(2 * 4 * DIV + 3);

        // Mid-frame load holds until the boundary
        step(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0001);
        run(2 * 4 * DIV);

        // Two loads in one frame, last one wins
        run(3);
        step(1'b0, 1'b1, 1'b1, 16'h00AB, 4'b0010);
        run(2);
        step(1'b0, 1'b1, 1'b1, 16'h00CD, 4'b0000);
        run(2 * 4 * DIV);

        // Staged value discarded by a load on the boundary itself
        step(1'b0, 1'b1, 1'b1, 16'h9999, 4'b1111);
        seek_boundary("seek_bnd1");
        step(1'b0, 1'b1, 1'b1, 16'h5678, 4'b0100);
        run(3 * 4 * DIV);

        // Enable drop mid-digit for 10 cycles
        run(DIV + 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        run(2 * 4 * DIV);

        // Load while dark commits directly
        step(1'b0, 1'b1, 1'b0, 16'h0F00, 4'b1000);
        run(4 * DIV + 2);

        // Reset mid-frame drops the staged value
        step(1'b0, 1'b1, 1'b1, 16'hABCD, 4'b1010);
        run(2);
        step(1'b1, 1'b0, 1'b1, 16'h0, 4'h0);
        run(2 * 4 * DIV);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            bit r, l, e;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 11) == 0) || (at_boundary_next() && $urandom_range(0, 1) == 1);
            step(r, l, e, 16'($urandom) & ($urandom_range(0, 2) == 0 ? 16'h00FF : 16'hFFFF),
                 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
